sum_sequencer: RTL and testbench

Automatic sweep engine between the input and output memory banks of the sequential memory lab. On a start pulse it reads a contiguous address range from the input bank and adds the two bytes of each word. It writes each zero-extended sum to the same address in the output bank, with the output address lagging the input address by one cycle. It replaces the manual hold-execute-and-right-button write sequence with a single command.

---
 rtl/sum_sequencer_pkg.sv | 22 ++
 rtl/sum_sequencer_byte_adder.sv | 13 +
 rtl/sum_sequencer.sv | 113 +++++++++++
 tb/tb_sum_sequencer.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sum_sequencer_pkg.sv
// Shared types and defaults for the sum sequencer sweep engine.
// State encoding, default bank geometry and the adder result width.
package sum_sequencer_pkg;

    localparam int ADDR_W_DEF = 4;
    localparam int DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        DONE
    } state_t;

    // Sum of two HALF_W addends needs one extra bit for the carry.
    function automatic int sum_width(input int half_w);
        return half_w + 1;
    endfunction

    localparam int SUM_W_DEF = sum_width(DATA_W_DEF / 2);

endpackage

// File: rtl/sum_sequencer_byte_adder.sv
// Adds the two halves of a bank word; combinational, zero latency.
// No flow control: result follows the operands in the same cycle.
module byte_adder #(
    parameter int HALF_W = 8
) (
    input  logic [HALF_W-1:0] a,
    input  logic [HALF_W-1:0] b,
    output logic [HALF_W:0]   sum
);

    assign sum = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/sum_sequencer.sv
// Sweeps lo..hi of the input bank, writes half-word sums to the output bank one cycle behind.
// N+2 cycles start-to-done; starts while busy are ignored, abort cancels without a done pulse.
module sum_sequencer
    import sum_sequencer_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int HALF_W = DATA_W / 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [ADDR_W-1:0]    lo_addr,
    input  logic [ADDR_W-1:0]    hi_addr,
    output logic [ADDR_W-1:0]    in_addr,
    output logic                 in_oe,
    input  logic [DATA_W-1:0]    in_data,
    output logic [ADDR_W-1:0]    out_addr,
    output logic                 out_we,
    output logic [DATA_W-1:0]    out_data,
    output logic                 busy,
    output logic                 done,
    output logic [2**ADDR_W-1:0] ovf_mask
);

    localparam int SUM_W = sum_width(HALF_W);

    state_t            state;
    logic [ADDR_W-1:0] hi_q;
    logic [SUM_W-1:0]  sum;

    byte_adder #(
        .HALF_W (HALF_W)
    ) u_byte_adder (
        .a   (in_data[DATA_W-1:HALF_W]),
        .b   (in_data[HALF_W-1:0]),
        .sum (sum)
    );

    // Read data arrives the cycle after the address, so the sum is gated by the write strobe.
    assign out_data = out_we ? DATA_W'(sum) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            hi_q     <= '0;
            in_addr  <= '0;
            in_oe    <= 1'b0;
            out_addr <= '0;
            out_we   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            ovf_mask <= '0;
        end else begin
            out_we <= in_oe && !abort;
            if (in_oe) begin
                out_addr <= in_addr;
            end
            if (out_we) begin
                ovf_mask[out_addr] <= sum[HALF_W];
            end

            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        hi_q     <= hi_addr;
                        ovf_mask <= '0;
                        if (lo_addr <= hi_addr) begin
                            state   <= READ;
                            in_addr <= lo_addr;
                            in_oe   <= 1'b1;
                            busy    <= 1'b1;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                READ: begin
                    // Compare before incrementing so hi = all-ones never wraps.
                    if (abort) begin
                        state <= IDLE;
                        in_oe <= 1'b0;
                        busy  <= 1'b0;
                    end else if (in_addr == hi_q) begin
                        state <= DRAIN;
                        in_oe <= 1'b0;
                    end else begin
                        in_addr <= in_addr + 1'b1;
                    end
                end
                DRAIN: begin
                    busy <= 1'b0;
                    if (abort) begin
                        state <= IDLE;
                    end else begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sum_sequencer.sv
// Testbench for sum_sequencer: cycle-level model built from the sweep timing rules,
// directed cases with literal expectations, then randomized sweeps with aborts and stray starts.
module tb_sum_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [3:0]  lo_addr = '0;
    logic [3:0]  hi_addr = '0;
    logic [3:0]  in_addr;
    logic        in_oe;
    logic [15:0] in_data = '0;
    logic [3:0]  out_addr;
    logic        out_we;
    logic [15:0] out_data;
    logic        busy;
    logic        done;
    logic [15:0] ovf_mask;

    always #5 clk = ~clk;

    sum_sequencer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .abort    (abort),
        .lo_addr  (lo_addr),
        .hi_addr  (hi_addr),
        .in_addr  (in_addr),
        .in_oe    (in_oe),
        .in_data  (in_data),
        .out_addr (out_addr),
        .out_we   (out_we),
        .out_data (out_data),
        .busy     (busy),
        .done     (done),
        .ovf_mask (ovf_mask)
    );

    // Input bank: registered read, data valid the cycle after the address.
    logic [15:0] mem [16];
    always @(posedge clk) if (in_oe) in_data <= mem[in_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail = 0;

    function automatic logic [15:0] exp_sum(input logic [15:0] w);
        return 16'(int'(w[15:8]) + int'(w[7:0]));
    endfunction

    function automatic bit carry_of(input logic [15:0] w);
        return (int'(w[15:8]) + int'(w[7:0])) > 255;
    endfunction

    // Model: m_t counts cycles since the accepting edge (cycle 1 is the first after it).
    bit          m_active = 0;
    int          m_t = 0;
    int          m_n = 0;
    int          m_lo = 0;
    logic [15:0] m_ovf = '0;

    function automatic int m_done_t();
        return (m_n == 0) ? 1 : m_n + 2;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active <= 0;
            m_t      <= 0;
            m_ovf    <= '0;
        end else if (!m_active) begin
            if (start && !abort) begin
                m_lo     <= int'(lo_addr);
                m_n      <= (hi_addr >= lo_addr) ? int'(hi_addr) - int'(lo_addr) + 1 : 0;
                m_t      <= 1;
                m_active <= 1;
                m_ovf    <= '0;
            end
        end else begin
            if (m_n > 0 && m_t >= 2 && m_t <= m_n + 1)
                m_ovf[m_lo + m_t - 2] <= carry_of(mem[m_lo + m_t - 2]);
            if (abort && m_n > 0 && m_t <= m_n + 1) m_active <= 0;
            else if (m_t >= m_done_t()) m_active <= 0;
            else m_t <= m_t + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    int          wr_cnt = 0;
    int          oe_cnt = 0;
    int          busy_cnt = 0;
    int          done_cnt = 0;
    int          wr_last = -1;
    logic [15:0] wr_data [16];

    task automatic compare_loop();
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_in_addr", in_addr, 0);
                chk("rst_out_addr", out_addr, 0);
                chk("rst_in_oe", in_oe, 0);
                chk("rst_out_we", out_we, 0);
                chk("rst_out_data", out_data, 0);
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                chk("rst_ovf_mask", ovf_mask, 0);
            end else begin
                bit          e_oe, e_we, e_busy, e_done;
                logic [15:0] e_data;
                e_oe   = m_active && m_t <= m_n;
                e_we   = m_active && m_n > 0 && m_t >= 2 && m_t <= m_n + 1;
                e_busy = m_active && m_n > 0 && m_t <= m_n + 1;
                e_done = m_active && m_t == m_done_t();
                e_data = '0;
                if (e_we) e_data = exp_sum(mem[m_lo + m_t - 2]);
                chk("in_oe", in_oe, e_oe);
                if (e_oe) chk("in_addr", in_addr, m_lo + m_t - 1);
                chk("out_we", out_we, e_we);
                if (e_we) chk("out_addr", out_addr, m_lo + m_t - 2);
                chk("out_data", out_data, e_data);
                chk("busy", busy, e_busy);
                chk("done", done, e_done);
                chk("ovf_mask", ovf_mask, m_ovf);
            end
            if (out_we) begin
                wr_cnt++;
                wr_last = int'(out_addr);
                wr_data[out_addr] = out_data;
            end
            if (in_oe) oe_cnt++;
            if (busy) busy_cnt++;
            if (done) done_cnt++;
        end
    endtask

    task automatic pulse_start(input int lo, input int hi, output int s);
        @(posedge clk);
        #1;
        start = 1'b1;
        lo_addr = lo[3:0];
        hi_addr = hi[3:0];
        s = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run_sweep(input int lo, input int hi, output int lat, output int nw);
        int  w0, s;
        bit  got;
        w0 = wr_cnt;
        got = 0;
        lat = -1;
        pulse_start(lo, hi, s);
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                got = 1;
                lat = cyc - s;
            end
        end
        if (!got) chk("done_timeout", 0, 1);
        @(negedge clk);
        #1;
        nw = wr_cnt - w0;
    endtask

    task automatic drain(input string name);
        bit idle;
        idle = 0;
        for (int i = 0; i < 40 && !idle; i++) begin
            @(negedge clk);
            #1;
            if (!m_active && busy === 1'b0 && done === 1'b0) idle = 1;
        end
        if (!idle) chk(name, 0, 1);
    endtask

    initial begin
        int lat, nw, s, w0, d0, b0, o0;
        bit found;
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat, nw, s, w0, d0, b0, o0;
        bit found;
        for (int k = 0; k < 16; k++) mem[k] = 16'(16'h0101 * k);
        fork
            compare_loop();
        join_none

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_ovf", ovf_mask, 16'h0000);

        // Full sweep 0..15
        run_sweep(0, 15, lat, nw);
        chk("full_latency", lat, 18);
        chk("full_writes", nw, 16);
        chk("full_wr5", wr_data[5], 16'd10);
        chk("full_wr15", wr_data[15], 16'd30);
        chk("full_ovf", ovf_mask, 16'h0000);

        // Overflow sweep 2..5
        mem[3] = 16'hFF01;
        mem[4] = 16'h8080;
        run_sweep(2, 5, lat, nw);
        chk("ovf_latency", lat, 6);
        chk("ovf_writes", nw, 4);
        chk("ovf_wr3", wr_data[3], 16'h0100);
        chk("ovf_wr4", wr_data[4], 16'h0100);
        chk("ovf_wr5", wr_data[5], 16'h000A);
        chk("ovf_mask", ovf_mask, 16'h0018);

        // Empty range
        o0 = oe_cnt;
        b0 = busy_cnt;
        run_sweep(9, 4, lat, nw);
        chk("empty_latency", lat, 1);
        chk("empty_writes", nw, 0);
        chk("empty_reads", oe_cnt - o0, 0);
        chk("empty_busy", busy_cnt - b0, 0);

        // Abort at in_addr 7, with a stray start while busy
        for (int k = 0; k < 16; k++) mem[k] = 16'(16'h0101 * k);
        w0 = wr_cnt;
        d0 = done_cnt;
        pulse_start(0, 15, s);
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk);
            if (in_oe === 1'b1 && in_addr == 4'd7) begin
                found = 1;
                abort = 1'b1;
            end else if (i == 2) begin
                start = 1'b1;
                lo_addr = 4'd12;
                hi_addr = 4'd13;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        if (!found) chk("abort_find_addr7", 0, 1);
        @(posedge clk);
        #1;
        abort = 1'b0;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_in_oe", in_oe, 0);
        chk("abort_out_we", out_we, 0);
        repeat (5) @(negedge clk);
        #1;
        chk("abort_no_done", done_cnt - d0, 0);
        chk("abort_last_wr", wr_last, 6);
        chk("abort_writes", wr_cnt - w0, 7);

        // Asynchronous reset mid-sweep
        for (int k = 0; k < 16; k++) mem[k] = 16'hF0F0;
        pulse_start(0, 15, s);
        repeat (6) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset_in_addr", in_addr, 0);
        chk("areset_out_addr", out_addr, 0);
        chk("areset_in_oe", in_oe, 0);
        chk("areset_out_we", out_we, 0);
        chk("areset_out_data", out_data, 0);
        chk("areset_busy", busy, 0);
        chk("areset_done", done, 0);
        chk("areset_ovf", ovf_mask, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_sweep(3, 8, lat, nw);
        chk("post_rst_latency", lat, 8);
        chk("post_rst_writes", nw, 6);
        chk("post_rst_wr3", wr_data[3], 16'h01E0);
        chk("post_rst_ovf", ovf_mask, 16'h01F8);

        // Randomized sweeps with occasional aborts and stray starts
        for (int it = 0; it < 12; it++) begin
            for (int k = 0; k < 16; k++) mem[k] = 16'($urandom);
            pulse_start($urandom_range(0, 15), $urandom_range(0, 15), s);
            for (int c = 0; c < 22; c++) begin
                @(posedge clk);
                #1;
                abort = ($urandom_range(0, 19) == 0);
                start = ($urandom_range(0, 5) == 0);
                lo_addr = 4'($urandom_range(0, 15));
                hi_addr = 4'($urandom_range(0, 15));
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            abort = 1'b0;
            drain("random_drain");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
